// File: rtl/apx_rt8_row.sv
// Row of W approximate 8-input reduction columns with chained carries,
// a registered valid/ready output stage and a saturating error-event counter.
module apx_rt8_row #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [8*W-1:0]   x,
   input  logic             cin1,
   input  logic             cin2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     sum,
   output logic [W-1:0]     carry,
   output logic             cout1,
   output logic             cout2,
   output logic [W-1:0]     err_mask,
   output logic             err_any,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   // Approximate 4:2 cell, packed as {s, co, e}; only a=b=c=d=1 is wrong (0 instead of 4).
   function automatic logic [2:0] cell4(input logic a, input logic b,
                                        input logic c, input logic d);
      logic s;
      logic co;
      logic e;
      s  = a ^ b ^ c ^ d;
      co = ((a ^ b) & (c | d)) | ((c & d) ? ~(a | b) : (a & b));
      e  = a & b & c & d;
      return {s, co, e};
   endfunction

   logic [W-1:0] sum_c;
   logic [W-1:0] carry_c;
   logic [W-1:0] err_c;
   logic         cout1_c;
   logic         cout2_c;
   logic         accept;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : col
         logic       ci1;
         logic       ci2;
         logic [2:0] u0;
         logic [2:0] u1;
         logic [2:0] u2;

         if (gi == 0) begin : g_first
            assign ci1 = cin1;
            assign ci2 = cin2;
         end else begin : g_chain
            assign ci1 = col[gi-1].u0[1];
            assign ci2 = col[gi-1].u1[1];
         end

         assign u0 = cell4(x[8*gi],   x[8*gi+1], x[8*gi+2], x[8*gi+3]);
         assign u1 = cell4(x[8*gi+4], x[8*gi+5], x[8*gi+6], x[8*gi+7]);
         assign u2 = cell4(u0[2], u1[2], ci1, ci2);

         assign sum_c[gi]   = u2[2];
         assign carry_c[gi] = u2[1];
         assign err_c[gi]   = u0[0] | u1[0] | u2[0];
      end
   endgenerate

   assign cout1_c = col[W-1].u0[1];
   assign cout2_c = col[W-1].u1[1];

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   assign err_any  = |err_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         carry     <= '0;
         cout1     <= 1'b0;
         cout2     <= 1'b0;
         err_mask  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         sum       <= sum_c;
         carry     <= carry_c;
         cout1     <= cout1_c;
         cout2     <= cout2_c;
         err_mask  <= err_c;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= '0;
      end else if (accept && (|err_c) && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_apx_rt8_row.sv
// Directed-vector bench for apx_rt8_row: a W=8 instance for the datapath and
// handshake, and a W=2/CNT_W=2 instance for counter saturation and clear.
module tb_apx_rt8_row;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] x = '0;
   logic        cin1 = 1'b0;
   logic        cin2 = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  sum;
   logic [7:0]  carry;
   logic        cout1;
   logic        cout2;
   logic [7:0]  err_mask;
   logic        err_any;
   logic        clr_cnt = 1'b0;
   logic [15:0] err_cnt;

   logic        in_valid2 = 1'b0;
   logic        in_ready2;
   logic [15:0] x2 = '0;
   logic        out_valid2;
   logic        out_ready2 = 1'b1;
   logic [1:0]  sum2;
   logic [1:0]  carry2;
   logic        cout1_2;
   logic        cout2_2;
   logic [1:0]  err_mask2;
   logic        err_any2;
   logic        clr_cnt2 = 1'b0;
   logic [1:0]  err_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apx_rt8_row #(.W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .cin1(cin1), .cin2(cin2), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .carry(carry), .cout1(cout1),
      .cout2(cout2), .err_mask(err_mask), .err_any(err_any),
      .clr_cnt(clr_cnt), .err_cnt(err_cnt)
   );

   apx_rt8_row #(.W(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .x(x2), .cin1(1'b0), .cin2(1'b0), .out_valid(out_valid2),
      .out_ready(out_ready2), .sum(sum2), .carry(carry2), .cout1(cout1_2),
      .cout2(cout2_2), .err_mask(err_mask2), .err_any(err_any2),
      .clr_cnt(clr_cnt2), .err_cnt(err_cnt2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One accepted beat with out_ready=1, then every output is checked.
   task automatic vec(input string tag, input logic [63:0] xv, input logic c1, input logic c2,
                      input logic [7:0] esum, input logic [7:0] ecarry,
                      input logic eco1, input logic eco2,
                      input logic [7:0] emask, input logic [15:0] ecnt);
      @(negedge clk);
      x = xv; cin1 = c1; cin2 = c2; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, ".out_valid"}, out_valid, 1'b1);
      chk({tag, ".sum"}, sum, esum);
      chk({tag, ".carry"}, carry, ecarry);
      chk({tag, ".couts"}, {cout1, cout2}, {eco1, eco2});
      chk({tag, ".err_mask"}, err_mask, emask);
      chk({tag, ".err_any"}, err_any, emask != 8'h00);
      chk({tag, ".err_cnt"}, err_cnt, ecnt);
      $display("beat %s x=%016h sum=%02h carry=%02h mask=%02h cnt=%0d",
               tag, xv, sum, carry, err_mask, err_cnt);
   endtask

   initial begin
      #2;
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.in_ready", in_ready, 1'b1);
      chk("rst.sum", sum, 8'h00);
      chk("rst.err_any", err_any, 1'b0);
      chk("rst.err_cnt", err_cnt, 16'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      vec("zero",   64'h0,                   1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);
      vec("x03",    64'h03,                  1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);
      vec("x0F",    64'h0F,                  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 16'd1);
      vec("x1133",  64'h1133,                1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 16'd2);
      vec("cout",   64'h3300_0000_0000_0011, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1, 8'h00, 16'd2);
      vec("cin11",  64'h01,                  1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 16'd2);
      vec("ones",   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 16'd3);

      // Backpressure: hold a result while an error beat waits.
      vec("bp_pre", 64'h03,                  1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 16'd3);
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; x = 64'h0F; cin1 = 1'b0; cin2 = 1'b0;
      #1;
      chk("bp.in_ready_low", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp.out_valid", out_valid, 1'b1);
         chk("bp.sum_hold", sum, 8'h02);
         chk("bp.mask_hold", err_mask, 8'h00);
         chk("bp.cnt_hold", err_cnt, 16'd3);
         chk("bp.in_ready", in_ready, 1'b0);
         $display("stall %0d out_valid=%0b sum=%02h cnt=%0d", i, out_valid, sum, err_cnt);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp.in_ready_high", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp.load_sum", sum, 8'h00);
      chk("bp.load_mask", err_mask, 8'h01);
      chk("bp.load_cnt", err_cnt, 16'd4);
      $display("release sum=%02h mask=%02h cnt=%0d", sum, err_mask, err_cnt);
      @(posedge clk);
      #1;
      chk("drain.out_valid", out_valid, 1'b0);
      chk("drain.mask_hold", err_mask, 8'h01);

      // Clear with no beat.
      @(negedge clk);
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
      chk("clr.err_cnt", err_cnt, 16'd0);

      // Asynchronous reset in the middle of a held result.
      vec("pre_rst", 64'h0F, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 16'd1);
      @(negedge clk);
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst.out_valid", out_valid, 1'b0);
      chk("arst.mask", err_mask, 8'h00);
      chk("arst.err_cnt", err_cnt, 16'd0);
      chk("arst.in_ready", in_ready, 1'b1);
      in_valid = 1'b1; x = 64'h0F;
      @(posedge clk);
      #1;
      chk("arst.no_accept", out_valid, 1'b0);
      chk("arst.no_cnt", err_cnt, 16'd0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1; rst = 1'b0;
      $display("reset mid-op out_valid=%0b cnt=%0d", out_valid, err_cnt);

      // Narrow counter saturates at 3; clear beats a same-cycle error beat.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid2 = 1'b1; x2 = 16'h000F; out_ready2 = 1'b1;
         @(posedge clk);
         #1;
         chk("sat.err_cnt", err_cnt2, (i < 3) ? 2'(i + 1) : 2'd3);
         chk("sat.mask", err_mask2, 2'b01);
         $display("sat beat %0d cnt=%0d", i, err_cnt2);
      end
      @(negedge clk);
      clr_cnt2 = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_pri.err_cnt", err_cnt2, 2'd0);
      $display("clear+error beat cnt=%0d", err_cnt2);
      @(negedge clk);
      clr_cnt2 = 1'b0; x2 = 16'hF000;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      chk("post_clr.err_cnt", err_cnt2, 2'd1);
      chk("post_clr.mask", err_mask2, 2'b10);
      $display("post-clear beat cnt=%0d mask=%02b", err_cnt2, err_mask2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apx_rt8_row.md
# apx_rt8_row

Parametrised row of approximate 8-input reduction columns for the approximate multiplier partial-product array. Each column compresses 8 partial-product bits plus two incoming carries using three approximate 4:2 cells. Carries chain from column to column across a W-column slice. The block adds a registered valid/ready output stage, per-column error flags and a saturating error-event counter for on-line accuracy monitoring.

## Interface
Parameters:
- W, default 8: number of columns (≥1).
- CNT_W, default 16: error counter width (≥2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- x  in  8*W  partial-product bits; column i uses x[8i+7:8i]; x[8i] is cell input x1.
- cin1, cin2  in  1  carries into column 0, sampled with the beat.
- out_valid  out  1  registered result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  W  registered column sums.
- carry  out  W  registered column carries (weight 2× its column).
- cout1, cout2  out  1  registered chain carries leaving column W-1.
- err_mask  out  W  registered per-column error flag.
- err_any  out  1  OR of err_mask.
- clr_cnt  in  1  synchronous clear of err_cnt.
- err_cnt  out  CNT_W  saturating count of accepted beats with err_any.

## Operation
Approximate 4:2 cell with inputs a,b,c,d and outputs s, co, e:
- s = a^b^c^d.
- co = ((a^b)&(c|d)) | (c&d ? ~(a|b) : a&b).
- e = a&b&c&d.
- The cell is exact except when all four inputs are 1. In that case it outputs s=0, co=0 (value 0 instead of 4) and e=1.

Column i:
- U0 takes x[8i+3:8i]. U1 takes x[8i+7:8i+4].
- U2 takes (U0.s, U1.s, cin1_i, cin2_i).
- cin1_0 = cin1 and cin2_0 = cin2. For i>0, cin1_i = U0.co and cin2_i = U1.co of column i-1.
- sum[i] = U2.s and carry[i] = U2.co.
- cout1 = U0.co and cout2 = U1.co of column W-1.
- Column error = U0.e | U1.e | U2.e.

The whole chain is combinational within one cycle. There is no internal pipelining between columns.

Handshake and output stage:
- in_ready = ~out_valid | out_ready.
- Accept = in_valid & in_ready. On accept, the output registers load the new results and out_valid becomes 1.
- out_valid & out_ready without accept: out_valid falls to 0 and the data registers hold.
- out_valid & ~out_ready: all output registers hold and in_ready=0.

err_cnt:
- Increments by 1 on accept when the new beat has any column error.
- Saturates at 2^CNT_W-1.
- clr_cnt forces 0 and takes priority over a simultaneous increment.

err_any is derived combinationally from the registered err_mask.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Reset (rst=1, asynchronous): out_valid=0, sum=0, carry=0, cout1=cout2=0, err_mask=0, err_any=0, err_cnt=0. in_ready=1 while in reset.
- Reset asserted mid-operation drops any held result. No beat is accepted while rst=1.
- err_cnt updates in the same edge as the accept. The new value is visible the cycle after.
- in_ready depends combinationally on out_ready. There is no other input-to-output combinational path.

## Test plan
- Reset, then x=0, cin1=cin2=0, one accept: next cycle out_valid=1, sum=0, carry=0, err_mask=0, err_cnt=0.
- W=8, x[7:0]=8'h03, rest 0: sum=8'h02, carry=0, err_mask=0. This checks chained carry into column 1.
- x[7:0]=8'h0F, rest 0: sum=0, carry=0, err_mask=8'h01, err_any=1, err_cnt=1.
- x[7:0]=8'h33, x[15:8]=8'h11, rest 0: column 1 U2 error; err_mask=8'h02, sum[1]=0, carry[1]=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1. Required: in_ready=0, outputs stable, err_cnt unchanged by stalled beats. Then out_ready=1: the next beat loads.
- CNT_W=2, four error beats: err_cnt saturates at 3. Then clr_cnt asserted with an error beat in the same cycle: err_cnt=0.
